// File: rtl/d_branch_predictor_if.sv
// Fetch/decode-side signal bundle for the dynamic branch predictor.
// The pipeline is the master. The predictor is the slave.
interface d_branch_predictor_if #(
    parameter int IDX_W = 6
);
    logic [31:0]      f_pc;
    logic             f_pred_taken;
    logic [IDX_W-1:0] f_idx;
    logic             d_valid;
    logic             d_is_cond;
    logic             d_stall;
    logic [IDX_W-1:0] d_idx;
    logic             d_pred_taken;
    logic             d_taken;
    logic             d_mispredict;

    modport master (
        output f_pc, d_valid, d_is_cond, d_stall, d_idx, d_pred_taken, d_taken,
        input  f_pred_taken, f_idx, d_mispredict
    );

    modport slave (
        input  f_pc, d_valid, d_is_cond, d_stall, d_idx, d_pred_taken, d_taken,
        output f_pred_taken, f_idx, d_mispredict
    );
endinterface

// File: rtl/d_branch_predictor.sv
// Saturating-counter conditional-branch predictor. The F stage reads the table and D resolves the branch.
// The predictor can index by PC alone (bimodal) or by PC xor global history (gshare).
module d_branch_predictor #(
    parameter int IDX_W    = 6,
    parameter int CNT_W    = 2,
    parameter int INIT_CNT = 1,
    parameter int MODE     = 0,
    parameter int STAT_W   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    d_branch_predictor_if.slave   bp,
    output logic [STAT_W-1:0]     br_count,
    output logic [STAT_W-1:0]     miss_count,
    output logic [IDX_W-1:0]      ghr
);

    localparam int              DEPTH    = 1 << IDX_W;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(INIT_CNT);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [CNT_W-1:0]  cnt_tab [DEPTH];
    logic [CNT_W-1:0]  cnt_rd;
    logic [CNT_W-1:0]  cnt_cur;
    logic [CNT_W-1:0]  cnt_next;
    logic [IDX_W-1:0]  pc_idx;
    logic [IDX_W-1:0]  ghr_reg;
    logic [STAT_W-1:0] br_reg;
    logic [STAT_W-1:0] br_next;
    logic [STAT_W-1:0] miss_reg;
    logic [STAT_W-1:0] miss_next;
    logic              upd;
    logic              miss;
    logic              unused_pc;

    assign pc_idx    = bp.f_pc[IDX_W+1:2];
    assign unused_pc = ^{bp.f_pc[31:IDX_W+2], bp.f_pc[1:0]};

    // A stalled D instruction resolves only on the cycle it is released.
    assign upd             = bp.d_valid & bp.d_is_cond & ~bp.d_stall;
    assign miss            = upd & (bp.d_pred_taken ^ bp.d_taken);
    assign bp.d_mispredict = miss;

    generate
        if (MODE == 1) begin : g_gshare
            // History advances only at resolution. It is never speculative.
            always_ff @(posedge clk) begin
                if (reset) begin
                    ghr_reg <= '0;
                end else if (upd) begin
                    ghr_reg <= {ghr_reg[IDX_W-2:0], bp.d_taken};
                end
            end
            assign bp.f_idx = pc_idx ^ ghr_reg;
        end else begin : g_bimodal
            assign ghr_reg  = '0;
            assign bp.f_idx = pc_idx;
        end
    endgenerate

    // The read has no bypass. A same-cycle update is seen by F on the next cycle.
    assign cnt_rd          = cnt_tab[bp.f_idx];
    assign bp.f_pred_taken = cnt_rd[CNT_W-1];
    assign cnt_cur         = cnt_tab[bp.d_idx];

    always_comb begin
        cnt_next = cnt_cur;
        if (bp.d_taken && (cnt_cur != CNT_MAX)) begin
            cnt_next = cnt_cur + 1'b1;
        end else if (!bp.d_taken && (cnt_cur != '0)) begin
            cnt_next = cnt_cur - 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_tab
            logic [CNT_W-1:0] entry_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    entry_reg <= CNT_INIT;
                end else if (upd && (bp.d_idx == IDX_W'(gi))) begin
                    entry_reg <= cnt_next;
                end
            end
            assign cnt_tab[gi] = entry_reg;
        end
    endgenerate

    always_comb begin
        br_next   = br_reg;
        miss_next = miss_reg;
        if (upd && (br_reg != '1)) begin
            br_next = br_reg + 1'b1;
        end
        if (miss && (miss_reg != '1)) begin
            miss_next = miss_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            br_reg   <= '0;
            miss_reg <= '0;
        end else begin
            br_reg   <= br_next;
            miss_reg <= miss_next;
        end
    end

    assign br_count   = br_reg;
    assign miss_count = miss_reg;
    assign ghr        = ghr_reg;

endmodule
